rc4_core: RTL and testbench

Parametrised RC4 engine for the key-search datapath: given a secret key, it runs KSA initialisation, the KSA shuffle and the PRGA/XOR decrypt. It drives an external single-port S RAM, reads ciphertext from an encrypted-data ROM and writes plaintext to a decrypted-data RAM. An optional plaintext check aborts early on the first invalid character, so a brute-force controller can step keys quickly. It replaces the per-task FSM chain with one self-sequenced block that is generic in key length and message depth.

---
 rtl/rc4_core.sv | 211 +++++++++++++++++++++
 tb/tb_rc4_core.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_core.sv
// rc4_core: self-sequenced RC4 engine (KSA init, KSA shuffle, PRGA/XOR decrypt).
// Ports: clk/reset/start/secret_key in; busy/done/key_valid out; S RAM, cipher ROM, plaintext RAM buses.
module rc4_core #(
    parameter int KEY_LENGTH = 3,
    parameter int MSG_DEPTH = 32,
    parameter int CHECK_ASCII = 1,
    localparam int AW = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [8*KEY_LENGTH-1:0] secret_key,
    output logic                    busy,
    output logic                    done,
    output logic                    key_valid,
    output logic [7:0]              s_address,
    output logic [7:0]              s_data_out,
    output logic                    s_wren,
    input  logic [7:0]              s_q,
    output logic [AW-1:0]           rom_address,
    input  logic [7:0]              rom_q,
    output logic [AW-1:0]           dec_address,
    output logic [7:0]              dec_data,
    output logic                    dec_wren
);

    localparam int KIW = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;
    localparam logic [KIW-1:0] KI_LAST = KIW'(KEY_LENGTH - 1);
    localparam logic [AW-1:0] K_LAST = AW'(MSG_DEPTH - 1);

    typedef enum logic [4:0] {
        IDLE, INIT,
        SH_RI, SH_LI, SH_RJ, SH_LJ, SH_WI, SH_WJ,
        PR_RI, PR_LI, PR_RJ, PR_LJ, PR_WI, PR_WJ,
        PR_RF, PR_LF, PR_WD, DONE
    } state_t;

    state_t                  state;
    logic [7:0]              i;
    logic [7:0]              j;
    logic [7:0]              si;
    logic [7:0]              sj;
    logic [AW-1:0]           k;
    logic [KIW-1:0]          kidx;
    logic [8*KEY_LENGTH-1:0] key_reg;
    logic [7:0]              key_bytes [2**KIW];
    logic [7:0]              j_sh;

    // Byte 0 is the most significant key byte; unused slots read as zero.
    for (genvar b = 0; b < 2**KIW; b++) begin : g_kb
        if (b < KEY_LENGTH) begin : g_on
            assign key_bytes[b] = key_reg[8*(KEY_LENGTH-1-b) +: 8];
        end else begin : g_off
            assign key_bytes[b] = 8'h00;
        end
    end

    always_comb begin
        j_sh = j + s_q + key_bytes[kidx];
    end

    function automatic logic ascii_ok(input logic [7:0] b);
        return (b == 8'h20) || (b >= 8'h61 && b <= 8'h7A);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            i           <= '0;
            j           <= '0;
            si          <= '0;
            sj          <= '0;
            k           <= '0;
            kidx        <= '0;
            key_reg     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            key_valid   <= 1'b0;
            s_address   <= '0;
            s_data_out  <= '0;
            s_wren      <= 1'b0;
            rom_address <= '0;
            dec_address <= '0;
            dec_data    <= '0;
            dec_wren    <= 1'b0;
        end else begin
            s_wren   <= 1'b0;
            dec_wren <= 1'b0;
            done     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state      <= INIT;
                        busy       <= 1'b1;
                        key_valid  <= 1'b0;
                        key_reg    <= secret_key;
                        i          <= '0;
                        s_address  <= '0;
                        s_data_out <= '0;
                        s_wren     <= 1'b1;
                    end
                end
                INIT: begin
                    if (i == 8'hFF) begin
                        state     <= SH_RI;
                        i         <= '0;
                        j         <= '0;
                        kidx      <= '0;
                        s_address <= '0;
                    end else begin
                        i          <= i + 8'd1;
                        s_address  <= i + 8'd1;
                        s_data_out <= i + 8'd1;
                        s_wren     <= 1'b1;
                    end
                end
                SH_RI: state <= SH_LI;
                SH_LI: begin
                    si        <= s_q;
                    j         <= j_sh;
                    s_address <= j_sh;
                    state     <= SH_RJ;
                end
                SH_RJ: state <= SH_LJ;
                SH_LJ: begin
                    sj         <= s_q;
                    s_address  <= i;
                    s_data_out <= s_q;
                    s_wren     <= 1'b1;
                    state      <= SH_WI;
                end
                SH_WI: begin
                    s_address  <= j;
                    s_data_out <= si;
                    s_wren     <= 1'b1;
                    state      <= SH_WJ;
                end
                SH_WJ: begin
                    if (i == 8'hFF) begin
                        // PRGA starts from i=0 and pre-increments, so first i is 1.
                        i           <= 8'd1;
                        j           <= '0;
                        k           <= '0;
                        rom_address <= '0;
                        s_address   <= 8'd1;
                        state       <= PR_RI;
                    end else begin
                        i         <= i + 8'd1;
                        kidx      <= (kidx == KI_LAST) ? '0 : kidx + 1'b1;
                        s_address <= i + 8'd1;
                        state     <= SH_RI;
                    end
                end
                PR_RI: state <= PR_LI;
                PR_LI: begin
                    si        <= s_q;
                    j         <= j + s_q;
                    s_address <= j + s_q;
                    state     <= PR_RJ;
                end
                PR_RJ: state <= PR_LJ;
                PR_LJ: begin
                    sj         <= s_q;
                    s_address  <= i;
                    s_data_out <= s_q;
                    s_wren     <= 1'b1;
                    state      <= PR_WI;
                end
                PR_WI: begin
                    s_address  <= j;
                    s_data_out <= si;
                    s_wren     <= 1'b1;
                    state      <= PR_WJ;
                end
                PR_WJ: begin
                    s_address <= si + sj;
                    state     <= PR_RF;
                end
                PR_RF: state <= PR_LF;
                PR_LF: begin
                    dec_address <= k;
                    dec_data    <= s_q ^ rom_q;
                    dec_wren    <= 1'b1;
                    state       <= PR_WD;
                end
                PR_WD: begin
                    if (CHECK_ASCII != 0 && !ascii_ok(dec_data)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        key_valid <= 1'b0;
                    end else if (k == K_LAST) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        key_valid <= 1'b1;
                    end else begin
                        k           <= k + 1'b1;
                        rom_address <= k + 1'b1;
                        i           <= i + 8'd1;
                        s_address   <= i + 8'd1;
                        state       <= PR_RI;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_core.sv
// tb_rc4_core: directed bench for rc4_core with S RAM, cipher ROM and plaintext RAM models.
// Three instances: depth 9 unchecked, depth 9 checked, depth 32 checked.
module tb_rc4_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start;
    logic [23:0] key;
    logic        clr;
    logic        track;
    int          cnt = 0;
    int          t0 = 0;
    int          checks = 0;
    int          failures = 0;

    logic       busy_a, done_a, kv_a, sw_a, dw_a;
    logic [7:0] sa_a, sd_a, sq_a, dd_a, rq_a;
    logic [3:0] ra_a, da_a;
    logic       busy_b, done_b, kv_b, sw_b, dw_b;
    logic [7:0] sa_b, sd_b, sq_b, dd_b, rq_b;
    logic [3:0] ra_b, da_b;
    logic       busy_c, done_c, kv_c, sw_c, dw_c;
    logic [7:0] sa_c, sd_c, sq_c, dd_c, rq_c;
    logic [4:0] ra_c, da_c;

    logic [7:0] s_a [256];
    logic [7:0] s_b [256];
    logic [7:0] s_c [256];
    logic [7:0] rom_ab [16];
    logic [7:0] rom_c [32];
    logic [7:0] dec_a [16];
    logic [7:0] dec_b [16];
    logic [7:0] dec_c [32];
    logic [7:0] exp_pt [9];
    logic [8*32-1:0] pt32;
    int nw_a, nw_b, nw_c;
    int ndone_a, ndone_b, ndone_c;
    int dcyc_a, dcyc_b, dcyc_c;
    int bad_busy, bad_both;

    rc4_core #(.KEY_LENGTH(3), .MSG_DEPTH(9), .CHECK_ASCII(0)) u_a (
        .clk(clk), .reset(reset), .start(start), .secret_key(key),
        .busy(busy_a), .done(done_a), .key_valid(kv_a),
        .s_address(sa_a), .s_data_out(sd_a), .s_wren(sw_a), .s_q(sq_a),
        .rom_address(ra_a), .rom_q(rq_a),
        .dec_address(da_a), .dec_data(dd_a), .dec_wren(dw_a));

    rc4_core #(.KEY_LENGTH(3), .MSG_DEPTH(9), .CHECK_ASCII(1)) u_b (
        .clk(clk), .reset(reset), .start(start), .secret_key(key),
        .busy(busy_b), .done(done_b), .key_valid(kv_b),
        .s_address(sa_b), .s_data_out(sd_b), .s_wren(sw_b), .s_q(sq_b),
        .rom_address(ra_b), .rom_q(rq_b),
        .dec_address(da_b), .dec_data(dd_b), .dec_wren(dw_b));

    rc4_core #(.KEY_LENGTH(3), .MSG_DEPTH(32), .CHECK_ASCII(1)) u_c (
        .clk(clk), .reset(reset), .start(start), .secret_key(key),
        .busy(busy_c), .done(done_c), .key_valid(kv_c),
        .s_address(sa_c), .s_data_out(sd_c), .s_wren(sw_c), .s_q(sq_c),
        .rom_address(ra_c), .rom_q(rq_c),
        .dec_address(da_c), .dec_data(dd_c), .dec_wren(dw_c));

    always @(posedge clk) cnt <= cnt + 1;

    // Memory models: read data one edge after the address, write on the edge.
    always @(posedge clk) begin
        sq_a <= s_a[sa_a];
        sq_b <= s_b[sa_b];
        sq_c <= s_c[sa_c];
        rq_a <= rom_ab[ra_a];
        rq_b <= rom_ab[ra_b];
        rq_c <= rom_c[ra_c];
        if (clr) begin
            for (int n = 0; n < 256; n++) begin
                s_a[n] <= ~8'(n);
                s_b[n] <= ~8'(n);
                s_c[n] <= ~8'(n);
            end
            for (int n = 0; n < 16; n++) begin
                dec_a[n] <= 8'h00;
                dec_b[n] <= 8'h00;
            end
            for (int n = 0; n < 32; n++) dec_c[n] <= 8'h00;
            nw_a <= 0;
            nw_b <= 0;
            nw_c <= 0;
        end else begin
            if (sw_a) s_a[sa_a] <= sd_a;
            if (sw_b) s_b[sa_b] <= sd_b;
            if (sw_c) s_c[sa_c] <= sd_c;
            if (dw_a) begin dec_a[da_a] <= dd_a; nw_a <= nw_a + 1; end
            if (dw_b) begin dec_b[da_b] <= dd_b; nw_b <= nw_b + 1; end
            if (dw_c) begin dec_c[da_c] <= dd_c; nw_c <= nw_c + 1; end
        end
    end

    always @(negedge clk) begin
        if (clr) begin
            ndone_a <= 0;
            ndone_b <= 0;
            ndone_c <= 0;
            bad_busy <= 0;
            bad_both <= 0;
        end else begin
            if (done_a) begin ndone_a <= ndone_a + 1; dcyc_a <= cnt - t0; end
            if (done_b) begin ndone_b <= ndone_b + 1; dcyc_b <= cnt - t0; end
            if (done_c) begin ndone_c <= ndone_c + 1; dcyc_c <= cnt - t0; end
            if (track && busy_c !== ((cnt - t0) >= 1 && (cnt - t0) <= 2080))
                bad_busy <= bad_busy + 1;
            if ((sw_a && dw_a) || (sw_b && dw_b) || (sw_c && dw_c))
                bad_both <= bad_both + 1;
        end
    end

    task automatic pulse_start(input logic [23:0] k);
        key = k;
        start = 1'b1;
        t0 = cnt;
        @(posedge clk);
        #1;
        start = 1'b0;
        clr = 1'b0;
    endtask

    task automatic wait_rel(input int r);
        while (cnt - t0 < r) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic build_roms();
        logic [7:0] s [256];
        logic [7:0] kb [3];
        logic [7:0] ii, jj, tmp, ks;
        logic [7:0] ct [9];
        ct = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        exp_pt = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
        for (int n = 0; n < 16; n++) rom_ab[n] = (n < 9) ? ct[n] : 8'h00;
        kb = '{8'h4B, 8'h65, 8'h79};
        for (int n = 0; n < 256; n++) s[n] = 8'(n);
        jj = 8'h00;
        for (int n = 0; n < 256; n++) begin
            jj = jj + s[n] + kb[n % 3];
            tmp = s[n];
            s[n] = s[jj];
            s[jj] = tmp;
        end
        ii = 8'h00;
        jj = 8'h00;
        for (int n = 0; n < 32; n++) begin
            ii = ii + 8'd1;
            jj = jj + s[ii];
            tmp = s[ii];
            s[ii] = s[jj];
            s[jj] = tmp;
            ks = s[8'(s[ii] + s[jj])];
            rom_c[n] = pt32[8*(31-n) +: 8] ^ ks;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b0;
        checks++;
        if ({busy_a, done_a, kv_a, sw_a, dw_a} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctl_a got=%b exp=00000", {busy_a, done_a, kv_a, sw_a, dw_a});
        end
        checks++;
        if ({sa_a, sd_a, ra_a, da_a, dd_a} !== 32'h0) begin
            failures++;
            $display("FAIL reset_bus_a got=%h exp=0", {sa_a, sd_a, ra_a, da_a, dd_a});
        end
        checks++;
        if ({busy_c, done_c, kv_c, sw_c, dw_c} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctl_c got=%b exp=00000", {busy_c, done_c, kv_c, sw_c, dw_c});
        end
        checks++;
        if ({sa_c, sd_c, ra_c, da_c, dd_c} !== 34'h0) begin
            failures++;
            $display("FAIL reset_bus_c got=%h exp=0", {sa_c, sd_c, ra_c, da_c, dd_c});
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_init_identity();
        int bad;
        pulse_start(24'h000000);
        checks++;
        if ({busy_a, sw_a, sa_a, sd_a} !== 18'h30000) begin
            failures++;
            $display("FAIL init_cycle1 got=%h exp=30000", {busy_a, sw_a, sa_a, sd_a});
        end
        wait_rel(257);
        bad = 0;
        for (int n = 0; n < 256; n++) if (s_a[n] !== 8'(n)) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL init_identity wrong_entries=%0d exp=0", bad);
        end
    endtask

    task automatic test_reset_midrun();
        wait_rel(900);
        checks++;
        if (busy_a !== 1'b1) begin
            failures++;
            $display("FAIL midrun_busy got=%b exp=1", busy_a);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({sw_a, busy_a} !== 2'b00) begin
            failures++;
            $display("FAIL reset_midrun_a got=%b exp=00", {sw_a, busy_a});
        end
        checks++;
        if ({sw_c, busy_c} !== 2'b00) begin
            failures++;
            $display("FAIL reset_midrun_c got=%b exp=00", {sw_c, busy_c});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({busy_a, done_a, kv_a, sw_a, dw_a, sa_a} !== 13'h0) begin
            failures++;
            $display("FAIL post_reset_idle got=%h exp=0", {busy_a, done_a, kv_a, sw_a, dw_a, sa_a});
        end
    endtask

    task automatic test_key_vector();
        int rel;
        int bad;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        track = 1'b1;
        pulse_start(24'h4B6579);
        rel = cnt - t0;
        while (ndone_c == 0 && rel <= 2300) begin
            @(posedge clk);
            #1;
            rel = cnt - t0;
            start = (rel == 10 || rel == 1000);
        end
        start = 1'b0;
        track = 1'b0;
        checks++;
        if (ndone_c == 0) begin
            failures++;
            $display("FAIL key_timeout got=no_done exp=done");
        end
        bad = 0;
        for (int n = 0; n < 9; n++) if (dec_a[n] !== exp_pt[n]) bad++;
        checks++;
        if (bad != 0 || nw_a != 9) begin
            failures++;
            $display("FAIL key_a_plain bad=%0d writes=%0d exp=0,9", bad, nw_a);
        end
        checks++;
        if (dcyc_a != 1874 || ndone_a != 1) begin
            failures++;
            $display("FAIL key_a_done cyc=%0d n=%0d exp=1874,1", dcyc_a, ndone_a);
        end
        checks++;
        if (kv_a !== 1'b1) begin
            failures++;
            $display("FAIL key_a_valid got=%b exp=1", kv_a);
        end
        checks++;
        if (nw_b != 1 || dec_b[0] !== 8'h50) begin
            failures++;
            $display("FAIL abort_b_writes n=%0d d0=%h exp=1,50", nw_b, dec_b[0]);
        end
        checks++;
        if (dcyc_b != 1802 || ndone_b != 1) begin
            failures++;
            $display("FAIL abort_b_done cyc=%0d n=%0d exp=1802,1", dcyc_b, ndone_b);
        end
        checks++;
        if (kv_b !== 1'b0) begin
            failures++;
            $display("FAIL abort_b_valid got=%b exp=0", kv_b);
        end
        bad = 0;
        for (int n = 0; n < 32; n++) if (dec_c[n] !== pt32[8*(31-n) +: 8]) bad++;
        checks++;
        if (bad != 0 || nw_c != 32) begin
            failures++;
            $display("FAIL full_c_plain bad=%0d writes=%0d exp=0,32", bad, nw_c);
        end
        checks++;
        if (dcyc_c != 2081 || ndone_c != 1) begin
            failures++;
            $display("FAIL full_c_done cyc=%0d n=%0d exp=2081,1", dcyc_c, ndone_c);
        end
        checks++;
        if (kv_c !== 1'b1) begin
            failures++;
            $display("FAIL full_c_valid got=%b exp=1", kv_c);
        end
        checks++;
        if (bad_busy != 0) begin
            failures++;
            $display("FAIL full_c_busy bad_cycles=%0d exp=0", bad_busy);
        end
        checks++;
        if (bad_both != 0) begin
            failures++;
            $display("FAIL dual_wren cycles=%0d exp=0", bad_both);
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        clr = 1'b1;
        pulse_start(24'h4B6579);
        checks++;
        if ({busy_c, busy_a, kv_a} !== 3'b110) begin
            failures++;
            $display("FAIL b2b_accept got=%b exp=110", {busy_c, busy_a, kv_a});
        end
        while (ndone_a == 0 && cnt - t0 < 2300) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (dcyc_a != 1874 || ndone_a != 1) begin
            failures++;
            $display("FAIL b2b_done cyc=%0d n=%0d exp=1874,1", dcyc_a, ndone_a);
        end
        bad = 0;
        for (int n = 0; n < 9; n++) if (dec_a[n] !== exp_pt[n]) bad++;
        checks++;
        if (bad != 0 || nw_a != 9 || kv_a !== 1'b1) begin
            failures++;
            $display("FAIL b2b_plain bad=%0d writes=%0d kv=%b exp=0,9,1", bad, nw_a, kv_a);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        key = 24'h0;
        clr = 1'b0;
        track = 1'b0;
        pt32 = "the quick brown fox jumps over a";
        build_roms();
        test_reset();
        test_init_identity();
        test_reset_midrun();
        test_key_vector();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
